busslave_multi: RTL and testbench
=================================

Name: busslave_multi

Overview:
- Parametrised successor of the single-channel bus slave.
- Serves one transaction at a time from any of N_MASTERS one-hot grant lines, with a per-transaction programmable wait-state count instead of a single wait bit.
- Returns a one-cycle acknowledge tagged with the granted master's index.
- Sits behind the arbiter on the shared bus; the arbiter consumes ack_vec to release its grant.

Parameters:
- N_MASTERS, 4: number of grant channels; legal range 2..16.
- WAIT_W, 4: width of the wait_cycles input.
- MAX_WAIT, 15: saturation limit for wait states; must be <= 2**WAIT_W-1.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- bus_grant, input, N_MASTERS: one-hot grant; all-zero means no grant.
- wait_cycles, input, WAIT_W: extra busy cycles for this transaction; sampled with the grant.
- bus_ack, output, 1: transaction-complete pulse, exactly one cycle wide.
- ack_vec, output, N_MASTERS: one-hot copy of bus_ack routed to the served master.
- ack_id, output, $clog2(N_MASTERS): binary index of the served master; valid while busy or bus_ack is high.
- busy, output, 1: high in BUSY and WAIT states.
- grant_err, output, 1: one-cycle pulse when a multi-hot grant is sampled.

Behaviour:
- Reset values, applied asynchronously: state=IDLE, bus_ack=0, ack_vec=0, ack_id=0, busy=0, grant_err=0, wait counter=0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, BUSY, WAIT, ACK.
- IDLE:
  - If bus_grant != 0 at a rising edge: go to BUSY.
  - On the same edge, latch ack_id = index of the lowest set bit of bus_grant, and latch wcnt = min(wait_cycles, MAX_WAIT).
  - If more than one bit of bus_grant is set: pulse grant_err for one cycle and still serve the lowest index.
- BUSY:
  - wcnt==0: go to ACK; set bus_ack=1 and ack_vec[ack_id]=1.
  - Otherwise: go to WAIT and decrement wcnt.
- WAIT:
  - Decrement wcnt each cycle.
  - When wcnt reaches 0 (the comparison uses the pre-decrement value 1), go to ACK and assert the ack outputs.
- ACK:
  - bus_ack and ack_vec are high for exactly this one cycle.
  - Next state is IDLE; clear bus_ack and ack_vec.
  - bus_grant is ignored in ACK, except as described under Optional Feature.
- Latency: grant sampled at edge k gives bus_ack high from edge k+2+W to edge k+3+W, where W is the saturated wait count.
  - W=0: ack 2 cycles after grant (matches the previous generation).
  - W=1: ack 3 cycles after grant (matches the previous waitstate=1 behaviour).
- Transaction rules:
  - Grant changes or drops while in BUSY/WAIT are ignored; the transaction completes for the latched master.
  - wait_cycles changes after sampling are ignored.
  - A grant held through ACK and back into IDLE starts a new transaction at the first IDLE edge. Minimum spacing is one IDLE cycle between acks.
- Saturation: wait_cycles > MAX_WAIT is treated as MAX_WAIT, with no error flagged.
- Reset mid-transaction: outputs clear immediately and asynchronously; the in-flight ack is lost, not replayed.
- busy is low in IDLE and ACK.

Optional Feature:
- Macro: BUSSLAVE_MULTI_B2B_EN.
- Defined: in ACK, a nonzero bus_grant is sampled exactly as in IDLE (latch id and wait count, go straight to BUSY). This removes the IDLE bubble, so the ack-to-ack period is 2+W cycles.
- Undefined: ACK always returns to IDLE; ack-to-ack period is at least 3+W cycles.
- In both cases bus_ack must never be high for two consecutive cycles.

Decomposition:
- Package arbitration gains:
  - typedef enum of busslave_multi states;
  - constant NO_GRANT_MULTI (all-zero) and function lowest_set_idx.
- Sub-module busslave_wait_ctr: WAIT_W-bit loadable down-counter with saturating load and a zero flag; instantiated once.

Test Plan:
- Reset, then bus_grant=4'b0100, wait_cycles=0 at edge 1 -> bus_ack=1, ack_vec=4'b0100, ack_id=2 during cycle 3 only; busy high in cycle 2.
- bus_grant=4'b0001, wait_cycles=5 -> busy high for 6 cycles, bus_ack pulses at edge 7 with ack_id=0.
- wait_cycles=4'hF with MAX_WAIT=3 -> ack 5 cycles after grant; grant_err stays 0.
- bus_grant=4'b1010 -> grant_err pulses one cycle, ack_id=1, ack_vec=4'b0010.
- Grant held continuously, wait_cycles=0 -> acks every 3 cycles without the macro, every 2 with BUSSLAVE_MULTI_B2B_EN.
- Assert reset during WAIT with wcnt=3 -> all outputs 0 immediately; no ack after release until a new grant arrives.

Source files
------------

// File: rtl/busslave_multi_pkg.sv
// Shared types and helpers for the multi-master bus slave: FSM state encoding,
// the all-zero grant constant and lowest-set-bit index extraction.
package busslave_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } busslave_multi_state_e;

    // Grant vectors are zero-extended to this width before index extraction.
    localparam int GRANT_MAX_W = 16;

    localparam logic [GRANT_MAX_W-1:0] NO_GRANT_MULTI = '0;

    function automatic logic [3:0] lowest_set_idx(input logic [GRANT_MAX_W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = GRANT_MAX_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/busslave_wait_ctr.sv
// Loadable wait-state down-counter; the load value saturates at MAX_WAIT and
// the zero flag tells the slave FSM when the wait phase is over.
module busslave_wait_ctr #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    localparam logic [WAIT_W-1:0] SAT_VAL = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val > SAT_VAL) ? SAT_VAL : load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/busslave_multi.sv
// Multi-master bus slave: serves one one-hot grant at a time, inserts a
// programmable number of wait states and returns a tagged one-cycle ack.
// Optional macro BUSSLAVE_MULTI_B2B_EN lets a grant seen in ACK start the next
// transaction immediately, removing the idle bubble between acks.
module busslave_multi
    import busslave_multi_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int WAIT_W    = 4,
    parameter int MAX_WAIT  = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         bus_grant,
    input  logic [WAIT_W-1:0]            wait_cycles,
    output logic                         bus_ack,
    output logic [N_MASTERS-1:0]         ack_vec,
    output logic [$clog2(N_MASTERS)-1:0] ack_id,
    output logic                         busy,
    output logic                         grant_err
);

    localparam int ID_W = $clog2(N_MASTERS);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUSY = ST_BUSY;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] ACK  = ST_ACK;

    logic [1:0]           state_d, state_q;
    logic                 bus_ack_d, bus_ack_q;
    logic [N_MASTERS-1:0] ack_vec_d, ack_vec_q;
    logic [ID_W-1:0]      ack_id_d, ack_id_q;
    logic                 busy_d, busy_q;
    logic                 grant_err_d, grant_err_q;

    logic [GRANT_MAX_W-1:0] grant_ext;
    logic                   grant_any;
    logic                   grant_multi;
    logic                   wcnt_load;
    logic                   wcnt_dec;
    logic                   wcnt_zero;

    always_comb begin
        grant_ext                 = NO_GRANT_MULTI;
        grant_ext[N_MASTERS-1:0]  = bus_grant;
    end

    assign grant_any   = (bus_grant != NO_GRANT_MULTI[N_MASTERS-1:0]);
    // Clearing the lowest set bit leaves something only for a multi-hot grant.
    assign grant_multi = ((bus_grant & (bus_grant - N_MASTERS'(1))) != '0);

    always_comb begin
        state_d     = state_q;
        ack_id_d    = ack_id_q;
        bus_ack_d   = 1'b0;
        ack_vec_d   = '0;
        grant_err_d = 1'b0;
        wcnt_load   = 1'b0;
        wcnt_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d     = BUSY;
                    ack_id_d    = ID_W'(lowest_set_idx(grant_ext));
                    grant_err_d = grant_multi;
                    wcnt_load   = 1'b1;
                end
            end
            BUSY, WAIT: begin
                if (wcnt_zero) begin
                    state_d   = ACK;
                    bus_ack_d = 1'b1;
                    ack_vec_d = N_MASTERS'(1) << ack_id_q;
                end else begin
                    state_d  = WAIT;
                    wcnt_dec = 1'b1;
                end
            end
            default: begin
`ifdef BUSSLAVE_MULTI_B2B_EN
                if (grant_any) begin
                    state_d     = BUSY;
                    ack_id_d    = ID_W'(lowest_set_idx(grant_ext));
                    grant_err_d = grant_multi;
                    wcnt_load   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase

        busy_d = (state_d == BUSY) || (state_d == WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_ack_q   <= 1'b0;
            ack_vec_q   <= '0;
            ack_id_q    <= '0;
            busy_q      <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_ack_q   <= bus_ack_d;
            ack_vec_q   <= ack_vec_d;
            ack_id_q    <= ack_id_d;
            busy_q      <= busy_d;
            grant_err_q <= grant_err_d;
        end
    end

    busslave_wait_ctr #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (wcnt_load),
        .load_val (wait_cycles),
        .dec      (wcnt_dec),
        .zero     (wcnt_zero)
    );

    assign bus_ack   = bus_ack_q;
    assign ack_vec   = ack_vec_q;
    assign ack_id    = ack_id_q;
    assign busy      = busy_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_busslave_multi.sv
// Directed self-checking bench for busslave_multi: a default instance plus a
// MAX_WAIT=3 instance for wait-count saturation.
module tb_busslave_multi;

    logic       clk;
    logic       reset;
    logic [3:0] bus_grant;
    logic [3:0] wait_cycles;

    logic       d_ack, d_busy, d_err;
    logic [3:0] d_vec;
    logic [1:0] d_id;
    logic       s_ack, s_busy, s_err;
    logic [3:0] s_vec;
    logic [1:0] s_id;

    int n_checks = 0;
    int n_errors = 0;

    busslave_multi #(.N_MASTERS(4), .WAIT_W(4), .MAX_WAIT(15)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus_grant   (bus_grant),
        .wait_cycles (wait_cycles),
        .bus_ack     (d_ack),
        .ack_vec     (d_vec),
        .ack_id      (d_id),
        .busy        (d_busy),
        .grant_err   (d_err)
    );

    busslave_multi #(.N_MASTERS(4), .WAIT_W(4), .MAX_WAIT(3)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .bus_grant   (bus_grant),
        .wait_cycles (wait_cycles),
        .bus_ack     (s_ack),
        .ack_vec     (s_vec),
        .ack_id      (s_id),
        .busy        (s_busy),
        .grant_err   (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus_grant   = 4'b0000;
        wait_cycles = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Counts edges from grant to the first ack; grant and wait_cycles are
    // disturbed after sampling to show they are ignored mid-transaction.
    task automatic measure(input bit use_sat, input int bound,
                           output int lat, output int busy_n, output int err_n,
                           output logic [1:0] id_at_ack);
        logic a, b, e;
        lat = 0; busy_n = 0; err_n = 0; id_at_ack = '0;
        for (int n = 1; n <= bound; n++) begin
            tick();
            if (n == 1) begin
                bus_grant   = 4'b0000;
                wait_cycles = 4'h9;
            end
            a = use_sat ? s_ack  : d_ack;
            b = use_sat ? s_busy : d_busy;
            e = use_sat ? s_err  : d_err;
            if (b) busy_n++;
            if (e) err_n++;
            if (a) begin
                lat       = n;
                id_at_ack = use_sat ? s_id : d_id;
                break;
            end
        end
    endtask

    int         lat, busy_n, err_n, acks, last_ack, exp_gap;
    logic [1:0] id_at_ack;
    logic       prev_ack;

    initial begin
        reset       = 1'b1;
        bus_grant   = 4'b0000;
        wait_cycles = 4'h0;

        // Reset state
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_ack",  32'(d_ack),  32'd0);
        check("rst_vec",  32'(d_vec),  32'd0);
        check("rst_id",   32'(d_id),   32'd0);
        check("rst_busy", 32'(d_busy), 32'd0);
        check("rst_err",  32'(d_err),  32'd0);
        reset = 1'b0;

        // Single grant, no wait states
        bus_grant = 4'b0100; wait_cycles = 4'h0;
        tick();
        bus_grant = 4'b0000;
        check("w0_busy_c2", 32'(d_busy), 32'd1);
        check("w0_ack_c2",  32'(d_ack),  32'd0);
        check("w0_id_c2",   32'(d_id),   32'd2);
        tick();
        check("w0_ack_c3",  32'(d_ack),  32'd1);
        check("w0_vec_c3",  32'(d_vec),  32'h4);
        check("w0_id_c3",   32'(d_id),   32'd2);
        check("w0_busy_c3", 32'(d_busy), 32'd0);
        tick();
        check("w0_ack_c4",  32'(d_ack),  32'd0);
        check("w0_vec_c4",  32'(d_vec),  32'd0);

        // Five wait states
        do_reset();
        bus_grant = 4'b0001; wait_cycles = 4'h5;
        measure(1'b0, 30, lat, busy_n, err_n, id_at_ack);
        check("w5_latency", 32'(lat),       32'd7);
        check("w5_busy_n",  32'(busy_n),    32'd6);
        check("w5_id",      32'(id_at_ack), 32'd0);
        check("w5_vec",     32'(d_vec),     32'h1);

        // One wait state
        do_reset();
        bus_grant = 4'b1000; wait_cycles = 4'h1;
        measure(1'b0, 30, lat, busy_n, err_n, id_at_ack);
        check("w1_latency", 32'(lat),       32'd3);
        check("w1_id",      32'(id_at_ack), 32'd3);

        // Saturation at MAX_WAIT=3, and full 15 on the default instance
        do_reset();
        bus_grant = 4'b0010; wait_cycles = 4'hF;
        measure(1'b1, 30, lat, busy_n, err_n, id_at_ack);
        check("sat_latency", 32'(lat),   32'd5);
        check("sat_err_n",   32'(err_n), 32'd0);
        check("sat_id",      32'(id_at_ack), 32'd1);
        do_reset();
        bus_grant = 4'b0010; wait_cycles = 4'hF;
        measure(1'b0, 40, lat, busy_n, err_n, id_at_ack);
        check("w15_latency", 32'(lat), 32'd17);

        // Multi-hot grant
        do_reset();
        bus_grant = 4'b1010; wait_cycles = 4'h0;
        tick();
        bus_grant = 4'b0000;
        check("mh_err_c2", 32'(d_err), 32'd1);
        check("mh_id_c2",  32'(d_id),  32'd1);
        tick();
        check("mh_err_c3", 32'(d_err), 32'd0);
        check("mh_ack_c3", 32'(d_ack), 32'd1);
        check("mh_vec_c3", 32'(d_vec), 32'h2);

        // Grant held continuously
        do_reset();
`ifdef BUSSLAVE_MULTI_B2B_EN
        exp_gap = 2;
`else
        exp_gap = 3;
`endif
        bus_grant = 4'b0100; wait_cycles = 4'h0;
        acks = 0; last_ack = 0; prev_ack = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("held_no_b2b", 32'(prev_ack && d_ack), 32'd0);
            if (d_ack) begin
                if (acks > 0) check("held_gap", 32'(n - last_ack), 32'(exp_gap));
                else          check("held_first", 32'(n), 32'd2);
                check("held_id", 32'(d_id), 32'd2);
                acks++;
                last_ack = n;
            end
            prev_ack = d_ack;
        end
        check("held_acks", 32'(acks), 32'(1 + (12 - 2) / exp_gap));
        bus_grant = 4'b0000;

        // Reset during WAIT with the counter at 3
        do_reset();
        bus_grant = 4'b1000; wait_cycles = 4'h5;
        tick();
        bus_grant = 4'b0000;
        tick();
        tick();
        check("mid_busy_pre", 32'(d_busy), 32'd1);
        check("mid_id_pre",   32'(d_id),   32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(d_busy), 32'd0);
        check("mid_ack",  32'(d_ack),  32'd0);
        check("mid_vec",  32'(d_vec),  32'd0);
        check("mid_id",   32'(d_id),   32'd0);
        check("mid_err",  32'(d_err),  32'd0);
        #1;
        reset = 1'b0;
        acks = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (d_ack || d_busy) acks++;
        end
        check("mid_no_replay", 32'(acks), 32'd0);
        bus_grant = 4'b0001; wait_cycles = 4'h0;
        measure(1'b0, 20, lat, busy_n, err_n, id_at_ack);
        check("mid_new_latency", 32'(lat), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
